// File: rtl/byte_word_packer_pkg.sv
// Shared types for the byte-to-word packer feeding the common-cells FIFO.
// The FSM has two states: collecting bytes, or holding a finished word for push.
package byte_word_packer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/byte_word_packer_counter.sv
// Free-running up-counter with synchronous clear and count enable.
// Used as the packer's idle-timeout counter.
module byte_word_packer_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next count: clear wins over enable.
   always_comb begin
      q_d = q_q;
      if (clear_i) begin
         q_d = {WIDTH{1'b0}};
      end else if (en_i) begin
         q_d = q_q + WIDTH'(1);
      end else begin
         q_d = q_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs an 8-bit valid/ready byte stream into little-endian DATA_WIDTH words with a
// lane mask, emitting partial words on last_i or after TIMEOUT idle cycles.
module byte_word_packer
   import byte_word_packer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic [7:0]              byte_i,
   input  logic                    byte_valid_i,
   input  logic                    last_i,
   output logic                    byte_ready_o,
   output logic [DATA_WIDTH-1:0]   word_o,
   output logic [DATA_WIDTH/8-1:0] be_o,
   output logic                    push_o,
   input  logic                    full_i,
   output logic                    busy_o
);

   localparam int unsigned NB_LANES = DATA_WIDTH / 8;
   localparam int unsigned LANE_W   = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
   localparam int unsigned CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          TO_EN    = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NB_LANES - 1);

   state_e                state_q, state_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [NB_LANES-1:0]   be_q, be_d;

   logic [CNT_W-1:0] cnt_s;
   logic             ready_s;
   logic             push_s;
   logic             accept_s;
   logic             idle_fill_s;
   logic             expire_s;
   logic             cnt_en_s;

   // Handshake and timeout decode; flush masks both handshakes in its own cycle.
   always_comb begin
      ready_s = 1'b0;
      push_s  = 1'b0;
      if (flush_i) begin
         ready_s = 1'b0;
         push_s  = 1'b0;
      end else if (state_q == FILL) begin
         ready_s = 1'b1;
      end else begin
         ready_s = !full_i;
         push_s  = !full_i;
      end
      accept_s    = byte_valid_i && ready_s;
      idle_fill_s = (state_q == FILL) && (lane_q != {LANE_W{1'b0}}) && !accept_s && !flush_i;
      expire_s    = TO_EN && idle_fill_s && (cnt_s == CNT_LAST);
      cnt_en_s    = TO_EN && idle_fill_s && !expire_s;
   end

   // Counting only while a partial word sits idle; any other condition clears it.
   byte_word_packer_counter #(
      .WIDTH (CNT_W)
   ) u_timeout_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (!cnt_en_s),
      .en_i    (cnt_en_s),
      .q_o     (cnt_s)
   );

   // Next-state: lane packing, word completion, push turnover and flush.
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      word_d  = word_q;
      be_d    = be_q;
      if (flush_i) begin
         state_d = FILL;
         lane_d  = {LANE_W{1'b0}};
         word_d  = {DATA_WIDTH{1'b0}};
         be_d    = {NB_LANES{1'b0}};
      end else begin
         case (state_q)
            FILL: begin
               if (accept_s) begin
                  for (int k = 0; k < NB_LANES; k++) begin
                     if (lane_q == LANE_W'(k)) begin
                        word_d[8*k +: 8] = byte_i;
                        be_d[k]          = 1'b1;
                     end else begin
                        word_d[8*k +: 8] = word_q[8*k +: 8];
                        be_d[k]          = be_q[k];
                     end
                  end
                  if ((lane_q == LANE_LAST) || last_i) begin
                     state_d = HOLD;
                     lane_d  = {LANE_W{1'b0}};
                  end else begin
                     lane_d  = lane_q + LANE_W'(1);
                  end
               end else if (expire_s) begin
                  state_d = HOLD;
                  lane_d  = {LANE_W{1'b0}};
               end else begin
                  state_d = FILL;
               end
            end
            HOLD: begin
               if (push_s) begin
                  // The word leaves this cycle; a byte taken now starts a fresh word.
                  if (accept_s) begin
                     word_d = {{(DATA_WIDTH-8){1'b0}}, byte_i};
                     be_d   = {{(NB_LANES-1){1'b0}}, 1'b1};
                     if (last_i) begin
                        state_d = HOLD;
                        lane_d  = {LANE_W{1'b0}};
                     end else begin
                        state_d = FILL;
                        lane_d  = LANE_W'(1);
                     end
                  end else begin
                     word_d  = {DATA_WIDTH{1'b0}};
                     be_d    = {NB_LANES{1'b0}};
                     state_d = FILL;
                     lane_d  = {LANE_W{1'b0}};
                  end
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d = FILL;
               lane_d  = {LANE_W{1'b0}};
               word_d  = {DATA_WIDTH{1'b0}};
               be_d    = {NB_LANES{1'b0}};
            end
         endcase
      end
   end

   // State, lane, word and lane-mask registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FILL;
         lane_q  <= {LANE_W{1'b0}};
         word_q  <= {DATA_WIDTH{1'b0}};
         be_q    <= {NB_LANES{1'b0}};
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         be_q    <= be_d;
      end
   end

   assign byte_ready_o = ready_s;
   assign push_o       = push_s;
   assign word_o       = word_q;
   assign be_o         = be_q;
   assign busy_o       = (state_q == HOLD) || (lane_q != {LANE_W{1'b0}});

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: per-cycle vector table plus hand sequences, with a
// scoreboard queue of expected words checked whenever the DUT pushes.
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [7:0]  byte_b;
   logic        valid;
   logic        last;
   logic        full;
   logic        ready;
   logic [31:0] word;
   logic [3:0]  be;
   logic        push;
   logic        busy;

   logic        valid0;
   logic        full0;
   logic        d0_ready;
   logic [31:0] d0_word;
   logic [3:0]  d0_be;
   logic        d0_push;
   logic        d0_busy;

   always #5 clk = ~clk;

   byte_word_packer #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .byte_i(byte_b),
      .byte_valid_i(valid), .last_i(last), .byte_ready_o(ready),
      .word_o(word), .be_o(be), .push_o(push), .full_i(full), .busy_o(busy)
   );

   byte_word_packer #(.DATA_WIDTH(32), .TIMEOUT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .byte_i(byte_b),
      .byte_valid_i(valid0), .last_i(last), .byte_ready_o(d0_ready),
      .word_o(d0_word), .be_o(d0_be), .push_o(d0_push), .full_i(full0), .busy_o(d0_busy)
   );

   typedef struct packed {
      logic [31:0] word;
      logic [3:0]  be;
   } exp_t;

   typedef struct {
      logic        v;
      logic [7:0]  b;
      logic        l;
      logic        f;
      logic        e_ready;
      logic        e_push;
      logic        e_busy;
      logic        chk_w;
      logic [31:0] e_word;
      logic [3:0]  e_be;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        vecs[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_word = 32'h0;
   logic [3:0]  m_be   = 4'h0;
   int          m_lane = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [7:0] b, input logic l);
      m_word[m_lane*8 +: 8] = b;
      m_be[m_lane]          = 1'b1;
      if (m_lane == 3 || l) begin
         exp_q.push_back({m_word, m_be});
         m_word = 32'h0;
         m_be   = 4'h0;
         m_lane = 0;
      end else begin
         m_lane++;
      end
   endtask

   task automatic model_timeout();
      exp_q.push_back({m_word, m_be});
      m_word = 32'h0;
      m_be   = 4'h0;
      m_lane = 0;
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_word = 32'h0;
      m_be   = 4'h0;
      m_lane = 0;
   endtask

   task automatic add(input logic v, input logic [7:0] b, input logic l, input logic f,
                      input logic er, input logic ep, input logic eb,
                      input logic cw = 1'b0, input logic [31:0] ew = 32'h0, input logic [3:0] ebe = 4'h0);
      vec_t t;
      t.v = v; t.b = b; t.l = l; t.f = f;
      t.e_ready = er; t.e_push = ep; t.e_busy = eb;
      t.chk_w = cw; t.e_word = ew; t.e_be = ebe;
      vecs.push_back(t);
   endtask

   // Called at posedge+1; drives, checks at the negedge, returns at the next posedge+1.
   task automatic cycle(input vec_t t);
      valid  = t.v;
      byte_b = t.b;
      last   = t.l;
      full   = t.f;
      @(negedge clk);
      check("ready", {31'h0, ready}, {31'h0, t.e_ready});
      check("push",  {31'h0, push},  {31'h0, t.e_push});
      check("busy",  {31'h0, busy},  {31'h0, t.e_busy});
      if (t.chk_w) begin
         check("word", word, t.e_word);
         check("be", {28'h0, be}, {28'h0, t.e_be});
      end
      if (t.v && t.e_ready) model_accept(t.b, t.l);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [7:0] b, input logic l, input logic f,
                       input logic er, input logic ep, input logic eb,
                       input logic cw = 1'b0, input logic [31:0] ew = 32'h0, input logic [3:0] ebe = 4'h0);
      vec_t t;
      t.v = v; t.b = b; t.l = l; t.f = f;
      t.e_ready = er; t.e_push = ep; t.e_busy = eb;
      t.chk_w = cw; t.e_word = ew; t.e_be = ebe;
      cycle(t);
   endtask

   // Scoreboard: every push must match the oldest expected word and never occur while full.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && push === 1'b1) begin
         check("push_vs_full", {31'h0, full}, 32'h0);
         if (exp_q.size() == 0) begin
            check("unexpected_push", 32'h1, {31'h0, push ^ 1'b1});
         end else begin
            e = exp_q.pop_front();
            check("sb_word", word, e.word);
            check("sb_be", {28'h0, be}, {28'h0, e.be});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushes0;
      int notbusy0;
      rst_n = 1'b0; flush = 1'b0; byte_b = 8'h00; valid = 1'b0; last = 1'b0;
      full = 1'b0; valid0 = 1'b0; full0 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full words back to back, then partial on last_i, then backpressure.
      add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
      add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF);
      add(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      add(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000AA, 4'h1);
      add(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3);
      add(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000CC, 4'h1);
      add(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00EEDDCC, 4'h7);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++)
         add(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF);
      add(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF);
      add(1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00006655, 4'h3);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < vecs.size(); i++) cycle(vecs[i]);

      // Timeout expiry with TIMEOUT=4: push five cycles after the single accept.
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      model_timeout();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000005A, 4'h1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // TIMEOUT=0: a lone byte is held indefinitely.
      valid0 = 1'b1; byte_b = 8'h5A;
      @(posedge clk); #1;
      valid0 = 1'b0;
      pushes0 = 0; notbusy0 = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (d0_push !== 1'b0) pushes0++;
         if (d0_busy !== 1'b1) notbusy0++;
      end
      check("to0_no_push", pushes0, 0);
      check("to0_busy", notbusy0, 0);
      @(posedge clk); #1;
      flush = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      flush = 1'b0;
      check("to0_flushed", {31'h0, d0_busy}, 32'h0);

      // Flush while holding a word against a full FIFO.
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      flush = 1'b1;
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      flush = 1'b0;
      model_clear();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0, (i != 1));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Flush at lane 2 with a byte offered in the flush cycle.
      step(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      flush = 1'b1;
      step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      flush = 1'b0;
      model_clear();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1, 1'b0, (i != 1));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h34333231, 4'hF);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-word, off the clock edge.
      step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      valid = 1'b0;
      check("pre_rst_busy", {31'h0, busy}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_push",  {31'h0, push},  32'h0);
      check("rst_ready", {31'h0, ready}, 32'h1);
      check("rst_busy",  {31'h0, busy},  32'h0);
      check("rst_word",  word, 32'h0);
      check("rst_be",    {28'h0, be}, 32'h0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC4C3C2C1, 4'hF);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
